// File: rtl/illum_trig_sequencer.sv
// Multi-laser / DLP / XTRIG pulse sequencer: LASER->DLP->EXPO->GAP pulses in
// continuous, N-pulse burst and laser-rotating burst modes.
module illum_trig_sequencer #(
  parameter int NUM_LASER = 4,
  parameter int CNT_W     = 16,
  parameter int PULSE_W   = 8,
  parameter bit XTRIG_POL = 1'b0
) (
  input  logic                 ctrl_clk_i,
  input  logic                 ctrl_rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 dlp_en_i,
  input  logic                 xtrig_en_i,
  input  logic [NUM_LASER-1:0] laser_mask_i,
  input  logic [1:0]           mode_i,
  input  logic [PULSE_W-1:0]   num_pulse_i,
  input  logic [CNT_W-1:0]     t_laser_i,
  input  logic [CNT_W-1:0]     t_dlp_i,
  input  logic [CNT_W-1:0]     t_expo_i,
  input  logic [CNT_W-1:0]     t_gap_i,
  output logic [NUM_LASER-1:0] laser_en_o,
  output logic                 dlp_en_o,
  output logic                 xtrig_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PULSE_W-1:0]   pulse_cnt_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LASER = 3'd1,
    DLP   = 3'd2,
    EXPO  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [1:0]           MODE_CONT = 2'd0;
  localparam logic [1:0]           MODE_ROT  = 2'd2;
  localparam logic [NUM_LASER-1:0] ONE_L     = 1;
  localparam logic [CNT_W-1:0]     ONE_C     = 1;
  localparam logic [PULSE_W-1:0]   ONE_P     = 1;

  state_t               state, state_nxt;
  logic [2:0]           start_sync;
  logic                 start_edge;
  logic                 start_ok;
  logic                 latch_cfg;
  logic                 accept;
  logic                 reject;
  logic [CNT_W-1:0]     timer;
  logic [CNT_W-1:0]     t_cur;
  logic                 phase_end;
  logic [PULSE_W-1:0]   pulse_cnt, cnt_nxt, cnt_inc;
  logic [NUM_LASER-1:0] laser_sel, sel_nxt, sel_rot, sel_higher;
  logic                 done_nxt;
  logic [NUM_LASER-1:0] mask_eff;
  logic [1:0]           mode_eff;
  logic                 lasers_on;

  logic [NUM_LASER-1:0] cfg_mask;
  logic [1:0]           cfg_mode;
  logic [PULSE_W-1:0]   cfg_num;
  logic [CNT_W-1:0]     cfg_t_laser, cfg_t_dlp, cfg_t_expo, cfg_t_gap;

  function automatic logic [NUM_LASER-1:0] lowest_bit(input logic [NUM_LASER-1:0] x);
    return x & (~x + ONE_L);
  endfunction

  // start_sync[1:0] synchronise start_i, start_sync[2] is the edge-detect history
  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      start_sync <= '0;
    end else begin
      start_sync <= {start_sync[1:0], start_i};
    end
  end

  assign start_edge = start_sync[1] & ~start_sync[2];
  assign start_ok   = (laser_mask_i != '0) && dlp_en_i && xtrig_en_i &&
                      !((mode_i != MODE_CONT) && (num_pulse_i == '0));
  assign latch_cfg  = start_edge && (state == IDLE) && !abort_i;
  assign accept     = latch_cfg && start_ok;
  assign reject     = latch_cfg && !start_ok;

  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      cfg_mask    <= '0;
      cfg_mode    <= '0;
      cfg_num     <= '0;
      cfg_t_laser <= '0;
      cfg_t_dlp   <= '0;
      cfg_t_expo  <= '0;
      cfg_t_gap   <= '0;
    end else if (latch_cfg) begin
      cfg_mask    <= laser_mask_i;
      cfg_mode    <= mode_i;
      cfg_num     <= num_pulse_i;
      cfg_t_laser <= t_laser_i;
      cfg_t_dlp   <= t_dlp_i;
      cfg_t_expo  <= t_expo_i;
      cfg_t_gap   <= t_gap_i;
    end
  end

  always_comb begin
    t_cur = '0;
    case (state)
      LASER:   t_cur = cfg_t_laser;
      DLP:     t_cur = cfg_t_dlp;
      EXPO:    t_cur = cfg_t_expo;
      GAP:     t_cur = cfg_t_gap;
      default: t_cur = '0;
    endcase
  end

  assign phase_end = (timer == t_cur);
  assign cnt_inc   = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + ONE_P;

  // Next enabled channel strictly above the current one, else wrap to the lowest
  assign sel_higher = cfg_mask & ~((laser_sel << 1) - ONE_L);
  assign sel_rot    = (sel_higher != '0) ? lowest_bit(sel_higher) : lowest_bit(cfg_mask);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = pulse_cnt;
    sel_nxt   = laser_sel;
    done_nxt  = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = LASER;
            cnt_nxt   = '0;
            sel_nxt   = lowest_bit(laser_mask_i);
          end else if (reject) begin
            done_nxt = 1'b1;
          end
        end
        LASER: if (phase_end) state_nxt = DLP;
        DLP:   if (phase_end) state_nxt = EXPO;
        EXPO:  if (phase_end) state_nxt = GAP;
        GAP: begin
          if (phase_end) begin
            cnt_nxt = cnt_inc;
            if ((cfg_mode != MODE_CONT) && (cnt_inc == cfg_num)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = LASER;
              sel_nxt   = sel_rot;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      state     <= IDLE;
      timer     <= '0;
      pulse_cnt <= '0;
      laser_sel <= '0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= cnt_nxt;
      laser_sel <= sel_nxt;
      if ((state_nxt != state) || (state_nxt == IDLE)) begin
        timer <= '0;
      end else begin
        timer <= timer + ONE_C;
      end
    end
  end

  // On the accepting cycle the shadow registers are still being loaded
  assign mask_eff  = accept ? laser_mask_i : cfg_mask;
  assign mode_eff  = accept ? mode_i : cfg_mode;
  assign lasers_on = (state_nxt == LASER) || (state_nxt == DLP) || (state_nxt == EXPO);

  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      laser_en_o <= '0;
      dlp_en_o   <= 1'b0;
      xtrig_o    <= ~XTRIG_POL;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      laser_en_o <= lasers_on ? ((mode_eff == MODE_ROT) ? sel_nxt : mask_eff) : '0;
      dlp_en_o   <= (state_nxt == DLP) || (state_nxt == EXPO);
      xtrig_o    <= (state_nxt == EXPO) ? XTRIG_POL : ~XTRIG_POL;
      busy_o     <= (state_nxt != IDLE);
      done_o     <= done_nxt;
    end
  end

  assign pulse_cnt_o = pulse_cnt;
  assign state_o     = state;

endmodule

// File: tb/tb_illum_trig_sequencer.sv
// Scoreboard bench for illum_trig_sequencer: a pulse-schedule model predicts
// per-pulse windows and end-of-sequence records; a monitor measures the DUT.
module tb_illum_trig_sequencer;

  localparam int NL = 4;
  localparam int CW = 16;
  localparam int PW = 8;
  localparam bit XP = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          dlp_en_i = 1'b1;
  logic          xtrig_en_i = 1'b1;
  logic [NL-1:0] laser_mask_i = '0;
  logic [1:0]    mode_i = '0;
  logic [PW-1:0] num_pulse_i = '0;
  logic [CW-1:0] t_laser_i = '0, t_dlp_i = '0, t_expo_i = '0, t_gap_i = '0;
  logic [NL-1:0] laser_en_o;
  logic          dlp_en_o, xtrig_o, busy_o, done_o;
  logic [PW-1:0] pulse_cnt_o;
  logic [2:0]    state_o;

  illum_trig_sequencer #(.NUM_LASER(NL), .CNT_W(CW), .PULSE_W(PW), .XTRIG_POL(XP)) dut (
    .ctrl_clk_i(clk), .ctrl_rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .dlp_en_i(dlp_en_i), .xtrig_en_i(xtrig_en_i), .laser_mask_i(laser_mask_i),
    .mode_i(mode_i), .num_pulse_i(num_pulse_i), .t_laser_i(t_laser_i),
    .t_dlp_i(t_dlp_i), .t_expo_i(t_expo_i), .t_gap_i(t_gap_i),
    .laser_en_o(laser_en_o), .dlp_en_o(dlp_en_o), .xtrig_o(xtrig_o),
    .busy_o(busy_o), .done_o(done_o), .pulse_cnt_o(pulse_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // is_end=0: one laser window; is_end=1: sequence end (done pulse or busy falling)
  typedef struct {
    bit            is_end;
    logic [NL-1:0] lval;
    int            lc, dc, xc;
    bit            done;
    int            run;
    int            cnt;
    bit            idle;
    int            stray;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  model_cnt = 0;

  function automatic ev_t blank_ev();
    ev_t e;
    e.is_end = 0; e.lval = '0; e.lc = 0; e.dc = 0; e.xc = 0;
    e.done = 0; e.run = 0; e.cnt = 0; e.idle = 0; e.stray = 0;
    return e;
  endfunction

  task automatic compareEvent(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got end=%0d lval=%b lc=%0d dc=%0d xc=%0d done=%0d run=%0d cnt=%0d, expected no event",
               got.is_end, got.lval, got.lc, got.dc, got.xc, got.done, got.run, got.cnt);
      return;
    end
    e = exp_q.pop_front();
    if (got.is_end != e.is_end || got.lval !== e.lval || got.lc != e.lc || got.dc != e.dc ||
        got.xc != e.xc || got.done != e.done || got.run != e.run || got.cnt != e.cnt ||
        got.idle != e.idle || got.stray != e.stray) begin
      errors++;
      $display("[TB] FAIL event_%s: got end=%0d lval=%b lc=%0d dc=%0d xc=%0d done=%0d run=%0d cnt=%0d idle=%0d stray=%0d, expected end=%0d lval=%b lc=%0d dc=%0d xc=%0d done=%0d run=%0d cnt=%0d idle=%0d stray=%0d",
               e.is_end ? "end" : "pulse",
               got.is_end, got.lval, got.lc, got.dc, got.xc, got.done, got.run, got.cnt, got.idle, got.stray,
               e.is_end, e.lval, e.lc, e.dc, e.xc, e.done, e.run, e.cnt, e.idle, e.stray);
    end
  endtask

  // Monitor: measures laser windows and sequence ends, independent of stimulus
  bit  in_pulse = 0;
  bit  prev_busy = 0;
  int  run_cnt = 0;
  int  stray_cnt = 0;
  ev_t cur;

  always @(negedge clk) begin
    ev_t endev;
    if (in_pulse && laser_en_o != cur.lval) begin
      compareEvent(cur);
      in_pulse = 0;
    end
    if (laser_en_o != '0) begin
      if (!in_pulse) begin
        cur = blank_ev();
        cur.lval = laser_en_o;
        in_pulse = 1;
      end
      cur.lc++;
      if (dlp_en_o) cur.dc++;
      if (xtrig_o == XP) cur.xc++;
    end else if (dlp_en_o || xtrig_o == XP) begin
      stray_cnt++;
    end
    if (busy_o) run_cnt++;
    if ((prev_busy && !busy_o) || (done_o && !prev_busy && !busy_o)) begin
      endev = blank_ev();
      endev.is_end = 1;
      endev.done = done_o;
      endev.run = (prev_busy && !busy_o) ? run_cnt : 0;
      endev.cnt = int'(pulse_cnt_o);
      endev.idle = (laser_en_o == '0) && !dlp_en_o && (xtrig_o == ~XP) && (state_o == 3'd0);
      endev.stray = stray_cnt;
      compareEvent(endev);
      if (prev_busy && !busy_o) run_cnt = 0;
      stray_cnt = 0;
    end
    prev_busy = busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if (laser_en_o !== '0 || dlp_en_o !== 1'b0 || xtrig_o !== ~XP || busy_o !== 1'b0 ||
        done_o !== 1'b0 || pulse_cnt_o !== '0 || state_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL %s: got laser=%b dlp=%b xtrig=%b busy=%b done=%b cnt=%0d state=%0d, expected laser=0 dlp=0 xtrig=%b busy=0 done=0 cnt=0 state=0",
               name, laser_en_o, dlp_en_o, xtrig_o, busy_o, done_o, pulse_cnt_o, state_o, ~XP);
    end
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d outstanding expected events, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Predicts the run from the phase lengths, then drives start (and optional
  // abort / reset / mid-run config scramble plus second start) at fixed cycle offsets.
  task automatic applyStimulus(input logic [1:0] mode, input logic [NL-1:0] mask, input int num,
                               input int tl, input int td, input int te, input int tg,
                               input bit den, input bit xen,
                               input int abort_at, input int reset_at, input bit scramble);
    ev_t e;
    logic [NL-1:0] rot[$];
    logic [NL-1:0] one = 1;
    int period, total, cnt_end, limit, rem, off, k;
    bit acc, done_exp;
    acc = (mask != '0) && den && xen && !((mode != 2'd0) && (num == 0));
    total = 0;
    if (!acc) begin
      e = blank_ev();
      e.is_end = 1; e.done = 1; e.run = 0; e.cnt = model_cnt; e.idle = 1;
      exp_q.push_back(e);
    end else begin
      period = tl + td + te + tg + 4;
      if (reset_at > 0) begin
        total = reset_at - 1; done_exp = 0; cnt_end = 0;
      end else if (abort_at > 0) begin
        total = abort_at; done_exp = 0; cnt_end = total / period;
        if (cnt_end > 255) cnt_end = 255;
      end else begin
        total = num * period; done_exp = 1; cnt_end = num;
      end
      for (int i = 0; i < NL; i++) if (mask[i]) rot.push_back(one << i);
      k = 0;
      while (k * period < total) begin
        off = k * period;
        rem = total - off;
        e = blank_ev();
        e.lval = (mode == 2'd2) ? rot[k % rot.size()] : mask;
        e.lc = (rem < tl + td + te + 3) ? rem : tl + td + te + 3;
        e.dc = rem - (tl + 1);
        if (e.dc < 0) e.dc = 0;
        if (e.dc > td + te + 2) e.dc = td + te + 2;
        e.xc = rem - (tl + td + 2);
        if (e.xc < 0) e.xc = 0;
        if (e.xc > te + 1) e.xc = te + 1;
        exp_q.push_back(e);
        k++;
      end
      e = blank_ev();
      e.is_end = 1; e.done = done_exp; e.run = total; e.cnt = cnt_end; e.idle = 1;
      exp_q.push_back(e);
      model_cnt = cnt_end;
    end

    mode_i = mode; laser_mask_i = mask; num_pulse_i = num[PW-1:0];
    t_laser_i = tl[CW-1:0]; t_dlp_i = td[CW-1:0]; t_expo_i = te[CW-1:0]; t_gap_i = tg[CW-1:0];
    dlp_en_i = den; xtrig_en_i = xen;
    start_i = 1'b1;
    limit = total + 12;
    for (int t = 1; t <= limit; t++) begin
      tick();
      if (t == 3) start_i = 1'b0;
      if (scramble && t == 6) begin
        laser_mask_i = NL'($urandom); mode_i = 2'($urandom); num_pulse_i = PW'($urandom);
        t_laser_i = CW'($urandom_range(0, 9)); t_dlp_i = CW'($urandom_range(0, 9));
        t_expo_i = CW'($urandom_range(0, 9)); t_gap_i = CW'($urandom_range(0, 9));
        dlp_en_i = 1'($urandom); xtrig_en_i = 1'($urandom);
      end
      if (scramble && t == 10) start_i = 1'b1;
      if (scramble && t == 12) start_i = 1'b0;
      if (abort_at > 0 && t == abort_at + 2) abort_i = 1'b1;
      if (abort_at > 0 && t == abort_at + 3) abort_i = 1'b0;
      if (reset_at > 0 && t == reset_at + 2) begin
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_sequence");
      end
      if (reset_at > 0 && t == reset_at + 3) rst = 1'b0;
    end
    checkDrained("sequence_drain");
  endtask

  initial begin
    int mode, mask, num, tl, td, te, tg, period, abort_at;
    bit den, xen, scr;
    #1 rst = 1'b1;
    #2 checkOutput("reset_state");
    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("after_reset");

    $display("[TB] burst of two pulses, lasers 0+1");
    applyStimulus(2'd1, 4'b0011, 2, 2, 1, 3, 0, 1, 1, 0, 0, 0);
    $display("[TB] rotating burst over mask 1010");
    applyStimulus(2'd2, 4'b1010, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    $display("[TB] start rejects");
    applyStimulus(2'd1, 4'b0101, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    applyStimulus(2'd1, 4'b0000, 3, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    applyStimulus(2'd3, 4'b0001, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(2'd0, 4'b0001, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    $display("[TB] continuous with abort in EXPO of pulse 5");
    applyStimulus(2'd0, 4'b0011, 0, 1, 1, 2, 1, 1, 1, 4 * 9 + 2 + 2 + 2, 0, 0);
    $display("[TB] mid-burst config change and second start");
    applyStimulus(2'd1, 4'b0110, 3, 2, 3, 4, 2, 1, 1, 0, 0, 1);
    $display("[TB] reset during DLP");
    applyStimulus(2'd1, 4'b0011, 2, 2, 1, 3, 0, 1, 1, 0, 4, 0);
    $display("[TB] abort wins over simultaneous start");
    mode_i = 2'd1; laser_mask_i = 4'b0001; num_pulse_i = 8'd1; dlp_en_i = 1; xtrig_en_i = 1;
    start_i = 1'b1;
    tick(); tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    repeat (15) tick();
    checkDrained("abort_start_priority");
    $display("[TB] pulse counter boundaries");
    applyStimulus(2'd1, 4'b0001, 255, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(2'd0, 4'b1000, 0, 0, 0, 0, 0, 1, 1, 260 * 4 + 3, 0, 0);

    $display("[TB] randomized sequences");
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 3);
      mask = $urandom_range(0, 15);
      num = $urandom_range(0, 4);
      tl = $urandom_range(0, 3); td = $urandom_range(0, 3);
      te = $urandom_range(0, 3); tg = $urandom_range(0, 3);
      den = ($urandom_range(0, 7) != 0);
      xen = ($urandom_range(0, 7) != 0);
      period = tl + td + te + tg + 4;
      abort_at = 0;
      if (mode == 0) abort_at = $urandom_range(1, 3 * period);
      else if (num > 0 && $urandom_range(0, 2) == 0) abort_at = $urandom_range(1, num * period - 1);
      if (abort_at > 0 && abort_at % period == 0) abort_at = abort_at - 1;
      scr = (mode != 0) && (abort_at == 0) && (num * period > 20) && ($urandom_range(0, 1) == 1);
      applyStimulus(mode[1:0], mask[NL-1:0], num, tl, td, te, tg, den, xen, abort_at, 0, scr);
    end

    repeat (5) tick();
    checkDrained("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
